// File: rtl/pipe5_types_pkg.sv
// Shared types for the 5-stage pipeline: fetch FSM states, F/D latch record and the canonical NOP.
package pipe5_types_pkg;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DISCARD = 2'd1,
      HOLD    = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault_insn;
      logic        mal_insn;
      logic [31:0] badaddr;
   } fd_latch_t;

   // Bubble keeps pc/badaddr so the latch only toggles what matters downstream.
   function automatic fd_latch_t fd_bubble(input fd_latch_t cur, input logic [31:0] nop);
      fd_latch_t b;
      b            = cur;
      b.valid      = 1'b0;
      b.instr      = nop;
      b.fault_insn = 1'b0;
      b.mal_insn   = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/pipe5_fd_latch.sv
// F/D pipeline register: flush beats stall, stall beats load, otherwise a bubble is loaded.
module pipe5_fd_latch
   import pipe5_types_pkg::*;
#(
   parameter logic [31:0] NOP_INSN = RV_NOP
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      flush_i,
   input  logic      stall_i,
   input  logic      load_i,
   input  fd_latch_t entry_i,
   output fd_latch_t entry_o
);

   fd_latch_t fd_q, fd_d;

   always_comb begin
      fd_d = fd_q;
      if (flush_i) begin
         fd_d = fd_bubble(fd_q, NOP_INSN);
      end else if (stall_i) begin
         fd_d = fd_q;
      end else if (load_i) begin
         fd_d = entry_i;
      end else begin
         fd_d = fd_bubble(fd_q, NOP_INSN);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fd_q <= '{valid: 1'b0, pc: 32'd0, instr: NOP_INSN, fault_insn: 1'b0,
                   mal_insn: 1'b0, badaddr: 32'd0};
      end else begin
         fd_q <= fd_d;
      end
   end

   assign entry_o = fd_q;

endmodule

// File: rtl/pipe5_fetch_stage.sv
// Fetch stage: owns the PC, issues one instruction read at a time, buffers a word while decode
// stalls and drops responses made stale by a redirect. Static not-taken prediction.
module pipe5_fetch_stage
   import pipe5_types_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0200,
   parameter logic [31:0] NOP_INSN = RV_NOP
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        pc_en,
   input  logic        npc_sel,
   input  logic [31:0] brj_addr,
   input  logic        insert_priv_pc,
   input  logic [31:0] priv_pc,
   input  logic        fd_stall,
   input  logic        fd_flush,
   output logic [31:0] iaddr,
   output logic        iren,
   input  logic [31:0] irdata,
   input  logic        ibusy,
   input  logic        ierror,
   output logic        f_busy,
   output logic        fault_insn,
   output logic        mal_insn,
   output logic [31:0] epc_f,
   output logic [31:0] badaddr_f,
   output logic        fd_valid,
   output logic [31:0] fd_pc,
   output logic [31:0] fd_instr
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  disc_addr_q, disc_addr_d;
   logic [31:0]  hold_instr_q, hold_instr_d;
   logic         hold_err_q, hold_err_d;

   logic         redirect, deliver, misaligned, load;
   logic [31:0]  target;
   fd_latch_t    entry, fd_q;

   assign redirect   = insert_priv_pc | npc_sel;
   assign target     = insert_priv_pc ? priv_pc : brj_addr;
   assign deliver    = pc_en & ~fd_stall & ~redirect;
   assign misaligned = (pc_q[1:0] != 2'b00);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      disc_addr_d  = disc_addr_q;
      hold_instr_d = hold_instr_q;
      hold_err_d   = hold_err_q;
      iren         = 1'b0;
      iaddr        = pc_q;
      load         = 1'b0;
      entry        = '{valid: 1'b1, pc: pc_q, instr: NOP_INSN, fault_insn: 1'b0,
                       mal_insn: 1'b0, badaddr: 32'd0};

      unique case (state_q)
         FETCH: begin
            if (misaligned) begin
               // No bus access: the fetch completes at once as a misaligned exception.
               entry.mal_insn = 1'b1;
               entry.badaddr  = pc_q;
               if (redirect) begin
                  pc_d = target;
               end else if (deliver) begin
                  load = 1'b1;
                  pc_d = pc_q + 32'd4;
               end
            end else begin
               iren = 1'b1;
               if (!ibusy) begin
                  if (redirect) begin
                     pc_d = target;
                  end else if (deliver) begin
                     load             = 1'b1;
                     pc_d             = pc_q + 32'd4;
                     entry.instr      = ierror ? NOP_INSN : irdata;
                     entry.fault_insn = ierror;
                     entry.badaddr    = ierror ? pc_q : 32'd0;
                  end else begin
                     hold_instr_d = irdata;
                     hold_err_d   = ierror;
                     state_d      = HOLD;
                  end
               end else if (redirect) begin
                  disc_addr_d = pc_q;
                  pc_d        = target;
                  state_d     = DISCARD;
               end
            end
         end
         DISCARD: begin
            // The in-flight beat cannot be cancelled; keep the old address until it drains.
            iren  = 1'b1;
            iaddr = disc_addr_q;
            if (redirect) pc_d = target;
            if (!ibusy) state_d = FETCH;
         end
         HOLD: begin
            entry.instr      = hold_err_q ? NOP_INSN : hold_instr_q;
            entry.fault_insn = hold_err_q;
            entry.badaddr    = hold_err_q ? pc_q : 32'd0;
            if (redirect) begin
               pc_d    = target;
               state_d = FETCH;
            end else if (deliver) begin
               load    = 1'b1;
               pc_d    = pc_q + 32'd4;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         disc_addr_q  <= 32'd0;
         hold_instr_q <= NOP_INSN;
         hold_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         disc_addr_q  <= disc_addr_d;
         hold_instr_q <= hold_instr_d;
         hold_err_q   <= hold_err_d;
      end
   end

   pipe5_fd_latch #(
      .NOP_INSN (NOP_INSN)
   ) u_fd_latch (
      .clk_i   (CLK),
      .rst_i   (RST),
      .flush_i (fd_flush),
      .stall_i (fd_stall),
      .load_i  (load),
      .entry_i (entry),
      .entry_o (fd_q)
   );

   assign f_busy     = ((state_q == FETCH) || (state_q == DISCARD)) && ibusy;
   assign fd_valid   = fd_q.valid;
   assign fd_pc      = fd_q.pc;
   assign fd_instr   = fd_q.instr;
   assign fault_insn = fd_q.fault_insn;
   assign mal_insn   = fd_q.mal_insn;
   assign epc_f      = fd_q.pc;
   assign badaddr_f  = fd_q.badaddr;

endmodule

// File: tb/tb_pipe5_fetch_stage.sv
// Directed bench for pipe5_fetch_stage with hand-computed expectations.
module tb_pipe5_fetch_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        pc_en, npc_sel, insert_priv_pc, fd_stall, fd_flush;
   logic [31:0] brj_addr, priv_pc, irdata;
   logic        ibusy, ierror;
   logic [31:0] iaddr, epc_f, badaddr_f, fd_pc, fd_instr;
   logic        iren, f_busy, fault_insn, mal_insn, fd_valid;

   int tests  = 0;
   int failed = 0;

   always #5 CLK = ~CLK;

   pipe5_fetch_stage dut (
      .CLK            (CLK),
      .RST            (RST),
      .pc_en          (pc_en),
      .npc_sel        (npc_sel),
      .brj_addr       (brj_addr),
      .insert_priv_pc (insert_priv_pc),
      .priv_pc        (priv_pc),
      .fd_stall       (fd_stall),
      .fd_flush       (fd_flush),
      .iaddr          (iaddr),
      .iren           (iren),
      .irdata         (irdata),
      .ibusy          (ibusy),
      .ierror         (ierror),
      .f_busy         (f_busy),
      .fault_insn     (fault_insn),
      .mal_insn       (mal_insn),
      .epc_f          (epc_f),
      .badaddr_f      (badaddr_f),
      .fd_valid       (fd_valid),
      .fd_pc          (fd_pc),
      .fd_instr       (fd_instr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; pc_en = 1'b1; npc_sel = 1'b0; insert_priv_pc = 1'b0;
      fd_stall = 1'b0; fd_flush = 1'b0; brj_addr = '0; priv_pc = '0;
      irdata = '0; ibusy = 1'b0; ierror = 1'b0;
      tick(); tick();

      // Reset state
      chk("rst_valid", 32'(fd_valid), 32'd0);
      chk("rst_instr", fd_instr, 32'h13);
      chk("rst_pc", fd_pc, 32'd0);
      chk("rst_fault", 32'(fault_insn), 32'd0);
      chk("rst_mal", 32'(mal_insn), 32'd0);
      chk("rst_epc", epc_f, 32'd0);
      chk("rst_badaddr", badaddr_f, 32'd0);
      chk("rst_iaddr", iaddr, 32'h200);

      // Zero-wait streaming
      RST = 1'b0; irdata = 32'd1; #1;
      chk("t1_iaddr0", iaddr, 32'h200);
      chk("t1_iren0", 32'(iren), 32'd1);
      tick(); irdata = 32'd2; #1;
      chk("t1_fdpc0", fd_pc, 32'h200);
      chk("t1_valid0", 32'(fd_valid), 32'd1);
      chk("t1_instr0", fd_instr, 32'd1);
      chk("t1_iaddr1", iaddr, 32'h204);
      tick(); irdata = 32'd3; #1;
      chk("t1_fdpc1", fd_pc, 32'h204);
      chk("t1_iaddr2", iaddr, 32'h208);
      tick();
      chk("t1_fdpc2", fd_pc, 32'h208);
      chk("t1_instr2", fd_instr, 32'd3);

      // Stall while 0x20C completes -> HOLD, then release
      fd_stall = 1'b1; irdata = 32'd4; #1;
      chk("t3_iaddr", iaddr, 32'h20C);
      tick();
      chk("t3_hold_iren", 32'(iren), 32'd0);
      chk("t3_hold_fdpc", fd_pc, 32'h208);
      irdata = 32'hdead_beef;
      tick();
      chk("t3_hold2_iren", 32'(iren), 32'd0);
      chk("t3_hold2_fdpc", fd_pc, 32'h208);
      fd_stall = 1'b0;
      tick();
      chk("t3_rel_fdpc", fd_pc, 32'h20C);
      chk("t3_rel_instr", fd_instr, 32'd4);
      chk("t3_next_iaddr", iaddr, 32'h210);

      // Busy bus then redirect mid-transfer -> DISCARD
      ibusy = 1'b1; irdata = 32'd5; #1;
      chk("t2_fbusy", 32'(f_busy), 32'd1);
      tick();
      chk("t2_bubble", 32'(fd_valid), 32'd0);
      chk("t2_iaddr_hold", iaddr, 32'h210);
      npc_sel = 1'b1; brj_addr = 32'h400;
      tick();
      npc_sel = 1'b0; #1;
      chk("t2_disc_iaddr", iaddr, 32'h210);
      chk("t2_disc_iren", 32'(iren), 32'd1);
      ibusy = 1'b0;
      tick();
      chk("t2_dropped", 32'(fd_valid), 32'd0);
      chk("t2_new_iaddr", iaddr, 32'h400);
      irdata = 32'd6;
      tick();
      chk("t2_fdpc", fd_pc, 32'h400);
      chk("t2_instr", fd_instr, 32'd6);

      // insert_priv_pc beats npc_sel
      insert_priv_pc = 1'b1; priv_pc = 32'h100; npc_sel = 1'b1; brj_addr = 32'h400;
      irdata = 32'h0bad;
      tick();
      insert_priv_pc = 1'b0; npc_sel = 1'b0; #1;
      chk("t4_iaddr", iaddr, 32'h100);
      chk("t4_bubble", 32'(fd_valid), 32'd0);
      irdata = 32'd7;
      tick();
      chk("t4_fdpc", fd_pc, 32'h100);

      // Misaligned redirect target
      npc_sel = 1'b1; brj_addr = 32'h402;
      tick();
      npc_sel = 1'b0; #1;
      chk("t5_iren", 32'(iren), 32'd0);
      tick();
      chk("t5_fdpc", fd_pc, 32'h402);
      chk("t5_mal", 32'(mal_insn), 32'd1);
      chk("t5_badaddr", badaddr_f, 32'h402);
      chk("t5_instr", fd_instr, 32'h13);
      chk("t5_valid", 32'(fd_valid), 32'd1);

      // Bus error at 0x300
      npc_sel = 1'b1; brj_addr = 32'h300;
      tick();
      npc_sel = 1'b0; ierror = 1'b1; irdata = 32'hdead;
      tick();
      ierror = 1'b0;
      chk("t6_fault", 32'(fault_insn), 32'd1);
      chk("t6_epc", epc_f, 32'h300);
      chk("t6_badaddr", badaddr_f, 32'h300);
      chk("t6_instr", fd_instr, 32'h13);
      chk("t6_mal", 32'(mal_insn), 32'd0);
      fd_flush = 1'b1; ibusy = 1'b1;
      tick();
      fd_flush = 1'b0; #1;
      chk("t6_flush_valid", 32'(fd_valid), 32'd0);
      chk("t6_flush_fault", 32'(fault_insn), 32'd0);
      chk("t6_busy_iaddr", iaddr, 32'h304);
      chk("t6_busy_fbusy", 32'(f_busy), 32'd1);

      // Asynchronous reset mid-transfer
      RST = 1'b1; #1;
      chk("t6_rst_iaddr", iaddr, 32'h200);
      chk("t6_rst_valid", 32'(fd_valid), 32'd0);
      chk("t6_rst_pc", fd_pc, 32'd0);
      chk("t6_rst_epc", epc_f, 32'd0);
      chk("t6_rst_badaddr", badaddr_f, 32'd0);
      chk("t6_rst_instr", fd_instr, 32'h13);
      tick();
      RST = 1'b0; ibusy = 1'b0; irdata = 32'd9;
      tick();
      chk("t6_post_fdpc", fd_pc, 32'h200);
      chk("t6_post_instr", fd_instr, 32'd9);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
